up_down_count_sequencer: RTL and testbench

//  Command-driven sequencer for a WIDTH-bit up/down counter. Accepts LOAD/UP/DOWN/CLEAR

---
 rtl/up_down_count_sequencer_if.sv | 47 ++++
 rtl/up_down_count_sequencer.sv | 175 +++++++++++++++++
 tb/tb_up_down_count_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/up_down_count_sequencer_if.sv
// ---------------------------------------------------------------------------
// up_down_count_sequencer_if
//   Command channel between a control master and the up/down count sequencer.
//
//   Handshake: the master raises cmd_valid with cmd_op/cmd_val/cmd_steps and
//   holds all of them stable until the slave accepts.  A command is accepted
//   on the rising edge where cmd_valid & cmd_ready are both high; cmd_ready
//   never depends on cmd_valid.  abort is a level side-band that travels with
//   the channel and is only looked at while a stepping command is running.
//
//   Signals
//     cmd_valid  master->slave  command present
//     cmd_ready  slave->master  sequencer idle and able to take a command
//     cmd_op     master->slave  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
//     cmd_val    master->slave  LOAD value
//     cmd_steps  master->slave  step count for UP/DOWN
//     abort      master->slave  stop a running UP/DOWN
// ---------------------------------------------------------------------------
interface up_down_count_sequencer_if #(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [WIDTH-1:0]  cmd_val;
  logic [STEP_W-1:0] cmd_steps;
  logic              abort;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_val,
    output cmd_steps,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_val,
    input  cmd_steps,
    input  abort,
    output cmd_ready
  );
endinterface

// File: rtl/up_down_count_sequencer.sv
// ---------------------------------------------------------------------------
// up_down_count_sequencer
//   Command-driven sequencer for a WIDTH-bit up/down counter.  LOAD and CLEAR
//   set the count directly; UP and DOWN step it once per cycle for a
//   programmed number of steps.  Each applied step is flagged by step_en in
//   the cycle whose closing edge applies it; the direction is presented on m.
//   With WRAP=1 the count wraps modulo 2^WIDTH, with WRAP=0 a run that would
//   step past 0 or 2^WIDTH-1 stops there and drops its remaining steps.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     cmd        command channel (slave side), see up_down_count_sequencer_if
//     m          direction of the current/last stepping command (1 = down)
//     step_en    a step is applied at the end of this cycle
//     count      current count
//     busy       not idle
//     done       one-cycle pulse ending every accepted command
//     boundary   sticky: wrap or saturation during the current/last command
//     aborted    sticky: current/last command ended by abort
//     dbg_state  FSM state (0 idle, 1 run, 2 done)
// ---------------------------------------------------------------------------
module up_down_count_sequencer #(
  parameter int WIDTH  = 3,
  parameter int STEP_W = 8,
  parameter int WRAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  up_down_count_sequencer_if.slave cmd,
  output logic                 m,
  output logic                 step_en,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic                 boundary,
  output logic                 aborted,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [WIDTH-1:0]  CNT_ONE = WIDTH'(1);
  localparam logic [STEP_W-1:0] REM_ONE = STEP_W'(1);
  localparam logic              SAT_MODE = (WRAP == 0);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              m_q, m_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              boundary_q, boundary_d;
  logic              aborted_q, aborted_d;

  logic              step_en_c;
  logic              at_limit;
  logic              sat_hit;

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      m_q        <= 1'b0;
      rem_q      <= '0;
      boundary_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      m_q        <= m_d;
      rem_q      <= rem_d;
      boundary_q <= boundary_d;
      aborted_q  <= aborted_d;
    end
  end

  // ------------------------------------------------------------------------
  // Next state and step generation
  // ------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    m_d        = m_q;
    rem_d      = rem_q;
    boundary_d = boundary_q;
    aborted_d  = aborted_q;
    step_en_c  = 1'b0;

    // The count sits at the end of its range in the current direction; the
    // next step would wrap (WRAP=1) or is refused (WRAP=0).
    at_limit = m_q ? (count_q == '0) : (count_q == CNT_MAX);
    sat_hit  = SAT_MODE & at_limit;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          // Status flags describe the command being accepted now.
          boundary_d = 1'b0;
          aborted_d  = 1'b0;
          unique case (cmd.cmd_op)
            OP_LOAD: begin
              count_d = cmd.cmd_val;
              state_d = S_DONE;
            end
            OP_CLEAR: begin
              count_d = '0;
              state_d = S_DONE;
            end
            OP_UP, OP_DOWN: begin
              m_d     = cmd.cmd_op[1];
              rem_d   = cmd.cmd_steps;
              state_d = (cmd.cmd_steps == '0) ? S_DONE : S_RUN;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_RUN: begin
        step_en_c = ~cmd.abort & ~sat_hit;
        if (cmd.abort || sat_hit) begin
          // Both conditions can hold in the same cycle; record each.
          aborted_d  = aborted_q | cmd.abort;
          boundary_d = boundary_q | sat_hit;
          rem_d      = '0;
          state_d    = S_DONE;
        end else begin
          count_d = m_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
          rem_d   = rem_q - REM_ONE;
          // Only reachable with WRAP=1: this step wraps the count.
          if (at_limit) begin
            boundary_d = 1'b1;
          end
          if (rem_q == REM_ONE) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign step_en       = step_en_c;
  assign count         = count_q;
  assign m             = m_q;
  assign boundary      = boundary_q;
  assign aborted       = aborted_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_up_down_count_sequencer.sv
// Bench drives two sequencers (WRAP=1 and WRAP=0) with identical commands and
// checks every cycle of every command against a trace computed from the
// command's arithmetic meaning.
module tb_up_down_count_sequencer;
  localparam int W  = 3;
  localparam int SW = 8;
  localparam int EW = 10;   // {ready, busy, done, step_en, boundary, aborted, m, count[2:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  up_down_count_sequencer_if #(.WIDTH(W), .STEP_W(SW)) ifw ();
  up_down_count_sequencer_if #(.WIDTH(W), .STEP_W(SW)) ifs ();

  logic         m_w, step_en_w, busy_w, done_w, boundary_w, aborted_w;
  logic [W-1:0] count_w;
  logic [1:0]   dbg_w;
  logic         m_s, step_en_s, busy_s, done_s, boundary_s, aborted_s;
  logic [W-1:0] count_s;
  logic [1:0]   dbg_s;

  up_down_count_sequencer #(.WIDTH(W), .STEP_W(SW), .WRAP(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .cmd(ifw),
    .m(m_w), .step_en(step_en_w), .count(count_w), .busy(busy_w),
    .done(done_w), .boundary(boundary_w), .aborted(aborted_w), .dbg_state(dbg_w)
  );

  up_down_count_sequencer #(.WIDTH(W), .STEP_W(SW), .WRAP(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .cmd(ifs),
    .m(m_s), .step_en(step_en_s), .count(count_s), .busy(busy_s),
    .done(done_s), .boundary(boundary_s), .aborted(aborted_s), .dbg_state(dbg_s)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_qw[$];
  logic [EW-1:0] exp_qs[$];

  // reference model state, index 0 = WRAP=1 instance, 1 = WRAP=0 instance
  int mdl_cnt[2];
  int mdl_dir[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pk(input int r, input int b, input int dn, input int se,
                                       input int bd, input int ab, input int dr, input int c);
    return {r[0], b[0], dn[0], se[0], bd[0], ab[0], dr[0], c[2:0]};
  endfunction

  function automatic logic [EW-1:0] obs_w();
    return {ifw.cmd_ready, busy_w, done_w, step_en_w, boundary_w, aborted_w, m_w, count_w};
  endfunction

  function automatic logic [EW-1:0] obs_s();
    return {ifs.cmd_ready, busy_s, done_s, step_en_s, boundary_s, aborted_s, m_s, count_s};
  endfunction

  task automatic push(input int d, input logic [EW-1:0] e);
    if (d == 0) exp_qw.push_back(e);
    else        exp_qs.push_back(e);
  endtask

  // Expected per-cycle trace of one command, from the cycle after acceptance
  // until the first idle cycle. ac = RUN cycle index carrying abort (0 = none).
  task automatic build(input int d, input int op, input int val, input int steps, input int ac);
    int  wrap, cnt, dir, bnd, abt, k, left, lim, ab, sat;
    bit  fin;
    wrap = (d == 0) ? 1 : 0;
    cnt  = mdl_cnt[d];
    dir  = mdl_dir[d];
    bnd  = 0;
    abt  = 0;
    if (op == 0) cnt = val;
    if (op == 3) cnt = 0;
    if (op == 1 || op == 2) dir = (op == 2) ? 1 : 0;
    if ((op == 1 || op == 2) && steps > 0) begin
      left = steps;
      k    = 1;
      fin  = 0;
      while (!fin) begin
        lim = (dir == 1) ? ((cnt == 0) ? 1 : 0) : ((cnt == 7) ? 1 : 0);
        ab  = (k == ac) ? 1 : 0;
        sat = (wrap == 0 && lim == 1) ? 1 : 0;
        push(d, pk(0, 1, 0, (ab == 0 && sat == 0) ? 1 : 0, bnd, abt, dir, cnt));
        if (ab == 1 || sat == 1) begin
          if (ab == 1)  abt = 1;
          if (sat == 1) bnd = 1;
          fin = 1;
        end else begin
          if (lim == 1) bnd = 1;
          cnt  = (dir == 1) ? (cnt + 7) % 8 : (cnt + 1) % 8;
          left = left - 1;
          if (left == 0) fin = 1;
          k++;
        end
      end
    end
    push(d, pk(0, 1, 1, 0, bnd, abt, dir, cnt));
    push(d, pk(1, 0, 0, 0, bnd, abt, dir, cnt));
    mdl_cnt[d] = cnt;
    mdl_dir[d] = dir;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cmd(input int op, input int val, input int steps);
    ifw.cmd_op = 2'(op);  ifw.cmd_val = 3'(val);  ifw.cmd_steps = 8'(steps);
    ifs.cmd_op = 2'(op);  ifs.cmd_val = 3'(val);  ifs.cmd_steps = 8'(steps);
  endtask

  // Issue one command to both instances and check every cycle until both are
  // idle again. poke keeps a conflicting LOAD on cmd_valid while busy.
  task automatic run_cmd(input int op, input int val, input int steps, input int ac, input bit poke);
    int  cyc;
    bit  hold;
    @(negedge clk);
    drive_cmd(op, val, steps);
    ifw.cmd_valid = 1'b1;  ifs.cmd_valid = 1'b1;
    ifw.abort = 1'b0;      ifs.abort = 1'b0;
    @(posedge clk);
    build(0, op, val, steps, ac);
    build(1, op, val, steps, ac);
    cyc = 1;
    while (exp_qw.size() > 0 || exp_qs.size() > 0) begin
      #1;
      hold = poke;
      if (exp_qw.size() == 0 || exp_qw[0][EW-1] == 1'b1) hold = 1'b0;
      if (exp_qs.size() == 0 || exp_qs[0][EW-1] == 1'b1) hold = 1'b0;
      if (hold) drive_cmd(0, 6, 0);
      ifw.cmd_valid = hold;  ifs.cmd_valid = hold;
      ifw.abort = (cyc == ac);  ifs.abort = (cyc == ac);
      @(negedge clk);
      if (exp_qw.size() > 0) check($sformatf("wrap op%0d c%0d", op, cyc), obs_w(), exp_qw.pop_front());
      if (exp_qs.size() > 0) check($sformatf("sat op%0d c%0d", op, cyc), obs_s(), exp_qs.pop_front());
      @(posedge clk);
      cyc++;
      if (cyc > 400) begin
        check("cycle budget", 0, 1);
        exp_qw.delete();
        exp_qs.delete();
      end
    end
    #1;
    ifw.cmd_valid = 1'b0;  ifs.cmd_valid = 1'b0;
    ifw.abort = 1'b0;      ifs.abort = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ifw.cmd_valid = 1'b0;  ifs.cmd_valid = 1'b0;
    ifw.abort = 1'b0;      ifs.abort = 1'b0;
    drive_cmd(0, 0, 0);
    mdl_cnt[0] = 0; mdl_cnt[1] = 0;
    mdl_dir[0] = 0; mdl_dir[1] = 0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset wrap", obs_w(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    check("reset sat",  obs_s(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    check("reset state wrap", dbg_w, 0);
    check("reset state sat",  dbg_s, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_cmd(0, 5, 0, 0, 0);    // LOAD 5
    run_cmd(1, 0, 4, 0, 0);    // UP 4: wrap 6,7,0,1 / saturate at 7
    run_cmd(0, 1, 0, 0, 0);    // LOAD 1
    run_cmd(2, 0, 3, 0, 0);    // DOWN 3: wrap 0,7,6 / saturate at 0
    run_cmd(3, 0, 0, 0, 0);    // CLEAR
    run_cmd(1, 0, 10, 3, 0);   // UP 10, abort in 3rd RUN cycle -> 2
    run_cmd(1, 0, 0, 0, 0);    // UP 0
    run_cmd(2, 0, 2, 0, 1);    // DOWN 2 with a command held while busy
    run_cmd(0, 7, 0, 0, 0);    // LOAD 7
    run_cmd(1, 0, 3, 1, 0);    // abort together with saturation in the sat instance
    run_cmd(0, 3, 0, 1, 0);    // abort level outside RUN is ignored

    // randomized commands
    for (int i = 0; i < 60; i++) begin
      int op, val, steps, ac;
      bit poke;
      op    = $urandom_range(0, 3);
      val   = $urandom_range(0, 7);
      steps = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 10);
      ac    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
      poke  = ($urandom_range(0, 3) == 0);
      run_cmd(op, val, steps, ac, poke);
    end

    // reset during the 2nd RUN cycle of UP 5
    run_cmd(0, 0, 0, 0, 0);
    @(negedge clk);
    drive_cmd(1, 0, 5);
    ifw.cmd_valid = 1'b1;  ifs.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    ifw.cmd_valid = 1'b0;  ifs.cmd_valid = 1'b0;
    @(negedge clk);
    check("pre-reset step wrap", obs_w(), pk(0, 1, 0, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check("pre-reset count wrap", count_w, 1);
    rst_n = 1'b0;
    #1;
    check("async reset wrap", obs_w(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    check("async reset sat",  obs_s(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("no done in reset wrap", done_w, 0);
    check("no done in reset sat",  done_s, 0);
    rst_n = 1'b1;
    mdl_cnt[0] = 0; mdl_cnt[1] = 0;
    mdl_dir[0] = 0; mdl_dir[1] = 0;
    @(negedge clk);
    check("no done after reset wrap", obs_w(), pk(1, 0, 0, 0, 0, 0, 0, 0));
    check("no done after reset sat",  obs_s(), pk(1, 0, 0, 0, 0, 0, 0, 0));

    run_cmd(2, 0, 2, 0, 0);    // recovery: DOWN 2 from 0

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL time limit reached total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "time limit");
  end
endmodule
